// File: rtl/otp_seg_capture.sv
// otp_seg_capture: decodes the multiplexed two-digit seven-segment bus back into OTP/user bytes.
// Define OTP_SEG_MATCH_EN to compile in the registered otp/user comparator driving `match`.
module otp_seg_capture #(
    parameter int STABLE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] lfsr_out,
    input  logic [6:0] user_out,
    input  logic [1:0] an,
    output logic [7:0] otp_byte,
    output logic [7:0] user_byte,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       match,
    output logic       seg_err
);
    localparam logic [3:0] STABLE_MAX = 4'(STABLE_SCANS);

    typedef enum logic [1:0] {WAIT_LO, WAIT_HI, EVAL} state_t;
    state_t state, state_nx;

    // Returns {legal, nibble} for an active-low {g,f,e,d,c,b,a} glyph.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h40:   seg_decode = 5'h10;
            7'h79:   seg_decode = 5'h11;
            7'h24:   seg_decode = 5'h12;
            7'h30:   seg_decode = 5'h13;
            7'h19:   seg_decode = 5'h14;
            7'h12:   seg_decode = 5'h15;
            7'h02:   seg_decode = 5'h16;
            7'h78:   seg_decode = 5'h17;
            7'h00:   seg_decode = 5'h18;
            7'h10:   seg_decode = 5'h19;
            7'h08:   seg_decode = 5'h1A;
            7'h03:   seg_decode = 5'h1B;
            7'h46:   seg_decode = 5'h1C;
            7'h21:   seg_decode = 5'h1D;
            7'h06:   seg_decode = 5'h1E;
            7'h0E:   seg_decode = 5'h1F;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    logic [4:0]  otp_dec, user_dec;
    logic        digit_ok, cap_lo, cap_hi, abort;
    logic [3:0]  otp_lo_p0, otp_hi_p0, user_lo_p0, user_hi_p0;
    logic [15:0] cand, prev_cand, cand_p1;
    logic        cand_vld, published, vld_p1, same, pub;
    logic [3:0]  stable_cnt, cnt_nx;

    assign otp_dec  = seg_decode(lfsr_out);
    assign user_dec = seg_decode(user_out);
    assign digit_ok = otp_dec[4] & user_dec[4];

    always_comb begin
        state_nx = state;
        cap_lo   = 1'b0;
        cap_hi   = 1'b0;
        abort    = 1'b0;
        case (state)
            WAIT_LO, WAIT_HI: begin
                if (an == 2'b00) begin
                    abort = 1'b1;
                end else if (an == 2'b10) begin
                    if (!digit_ok) abort = 1'b1;
                    else begin
                        cap_lo   = 1'b1;
                        state_nx = WAIT_HI;
                    end
                end else if (an == 2'b01) begin
                    // A high digit seen before any low digit is legal but not captured.
                    if (!digit_ok) abort = 1'b1;
                    else if (state == WAIT_HI) begin
                        cap_hi   = 1'b1;
                        state_nx = EVAL;
                    end
                end
                if (abort) state_nx = WAIT_LO;
            end
            default: state_nx = WAIT_LO;
        endcase
    end

    assign cand   = {otp_hi_p0, otp_lo_p0, user_hi_p0, user_lo_p0};
    assign same   = cand_vld && (cand == prev_cand);
    assign cnt_nx = !same ? 4'd1 : (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 4'd1;
    // Saturated count keeps a backpressured pair eligible until byte_valid drops.
    assign pub    = (state == EVAL) && (cnt_nx == STABLE_MAX) && !byte_valid &&
                    (!published || (cand != {otp_byte, user_byte}));

    // ---- stage p0: digit capture and candidate history ----
    always_ff @(posedge clk) begin
        if (cap_lo) begin
            otp_lo_p0  <= otp_dec[3:0];
            user_lo_p0 <= user_dec[3:0];
        end
        if (cap_hi) begin
            otp_hi_p0  <= otp_dec[3:0];
            user_hi_p0 <= user_dec[3:0];
        end
        if (state == EVAL) prev_cand <= cand;
        if (pub) cand_p1 <= cand;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_LO;
            stable_cnt <= 4'd0;
            cand_vld   <= 1'b0;
            vld_p1     <= 1'b0;
            seg_err    <= 1'b0;
        end else begin
            state   <= state_nx;
            seg_err <= abort;
            vld_p1  <= pub;
            if (abort) begin
                stable_cnt <= 4'd0;
                cand_vld   <= 1'b0;
            end else if (state == EVAL) begin
                stable_cnt <= cnt_nx;
                cand_vld   <= 1'b1;
            end
        end
    end

    // ---- stage p1: publish and handshake ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_valid <= 1'b0;
            otp_byte   <= 8'h00;
            user_byte  <= 8'h00;
            published  <= 1'b0;
`ifdef OTP_SEG_MATCH_EN
            match      <= 1'b0;
`endif
        end else if (vld_p1) begin
            byte_valid              <= 1'b1;
            {otp_byte, user_byte}   <= cand_p1;
            published               <= 1'b1;
`ifdef OTP_SEG_MATCH_EN
            match                   <= (cand_p1[15:8] == cand_p1[7:0]);
`endif
        end else if (byte_valid && byte_ready) begin
            byte_valid <= 1'b0;
        end
    end

`ifndef OTP_SEG_MATCH_EN
    assign match = 1'b0;
`endif

endmodule

// File: tb/tb_otp_seg_capture.sv
// tb_otp_seg_capture: randomized and directed scans against a scan-level reference model.
module tb_otp_seg_capture;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] lfsr_out = 7'h7F;
    logic [6:0] user_out = 7'h7F;
    logic [1:0] an = 2'b11;
    logic       byte_ready = 1'b0;
    logic [7:0] otp_byte, user_byte;
    logic       byte_valid, match, seg_err;

    always #5 clk = ~clk;

    otp_seg_capture #(.STABLE_SCANS(S)) dut (
        .clk(clk), .reset_n(reset_n), .lfsr_out(lfsr_out), .user_out(user_out), .an(an),
        .otp_byte(otp_byte), .user_byte(user_byte), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .match(match), .seg_err(seg_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40; 4'h1: glyph = 7'h79; 4'h2: glyph = 7'h24; 4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19; 4'h5: glyph = 7'h12; 4'h6: glyph = 7'h02; 4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00; 4'h9: glyph = 7'h10; 4'hA: glyph = 7'h08; 4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46; 4'hD: glyph = 7'h21; 4'hE: glyph = 7'h06; default: glyph = 7'h0E;
        endcase
    endfunction

    // Reference model state: expected outputs plus scan-run bookkeeping.
    logic        exp_valid = 1'b0, exp_match = 1'b0;
    logic [7:0]  exp_otp = 8'h00, exp_user = 8'h00;
    int          run_cnt = 0;
    logic [15:0] run_val = 16'h0;
    bit          pub_seen = 0;
    bit          eval_pend = 0, pub_pend = 0;
    logic [15:0] eval_val = 16'h0, pub_val = 16'h0;
    bit          hi_flag = 0, abort_flag = 0;
    logic [15:0] hi_val = 16'h0;
    int          err_obs = 0, err_exp = 0;
    int          rdy_mode = 1;

    task automatic model_reset();
        exp_valid = 1'b0; exp_match = 1'b0; exp_otp = 8'h00; exp_user = 8'h00;
        run_cnt = 0; pub_seen = 0; eval_pend = 0; pub_pend = 0;
        hi_flag = 0; abort_flag = 0;
    endtask

    task automatic tick();
        bit          hs;
        bit          npend;
        logic [15:0] nval;
        if (rdy_mode == 2) byte_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        hs    = exp_valid && byte_ready;
        npend = 0;
        nval  = pub_val;
        if (eval_pend) begin
            if (run_cnt > 0 && eval_val == run_val) begin
                if (run_cnt < S) run_cnt++;
            end else begin
                run_cnt = 1;
                run_val = eval_val;
            end
            if (run_cnt == S && !exp_valid && (!pub_seen || eval_val != {exp_otp, exp_user})) begin
                npend = 1;
                nval  = eval_val;
            end
        end
        if (abort_flag) begin
            run_cnt = 0;
            err_exp++;
        end
        if (hs) exp_valid = 1'b0;
        if (pub_pend) begin
            exp_valid = 1'b1;
            {exp_otp, exp_user} = pub_val;
`ifdef OTP_SEG_MATCH_EN
            exp_match = (pub_val[15:8] == pub_val[7:0]);
`else
            exp_match = 1'b0;
`endif
            pub_seen = 1;
        end
        pub_pend   = npend;
        pub_val    = nval;
        eval_pend  = hi_flag;
        eval_val   = hi_val;
        hi_flag    = 0;
        abort_flag = 0;
        #1;
        if (seg_err) err_obs++;
        check("byte_valid", 32'(byte_valid), 32'(exp_valid));
        check("otp_byte", 32'(otp_byte), 32'(exp_otp));
        check("user_byte", 32'(user_byte), 32'(exp_user));
        check("match", 32'(match), 32'(exp_match));
    endtask

    task automatic drive(input logic [1:0] a, input logic [6:0] l, input logic [6:0] u);
        an = a; lfsr_out = l; user_out = u;
    endtask

    task automatic scan(input logic [7:0] o, input logic [7:0] usr,
                        input int lo_n, input int gap_n, input int hi_n, input int tail_n);
        drive(2'b10, glyph(o[3:0]), glyph(usr[3:0]));
        repeat (lo_n) tick();
        drive(2'b11, 7'h7F, 7'h7F);
        repeat (gap_n) tick();
        drive(2'b01, glyph(o[7:4]), glyph(usr[7:4]));
        hi_flag = 1;
        hi_val  = {o, usr};
        repeat (hi_n) tick();
        drive(2'b11, 7'h7F, 7'h7F);
        repeat (tail_n) tick();
        check("seg_err_count", 32'(err_obs), 32'(err_exp));
    endtask

    // kind 0: illegal low pattern, 1: an=00, 2: illegal high pattern on user bus
    task automatic bad_scan(input int kind);
        drive(2'b10, glyph(4'h5), glyph(4'h5));
        repeat (2) tick();
        case (kind)
            0:       drive(2'b10, 7'h7F, glyph(4'h5));
            1:       drive(2'b00, glyph(4'h5), glyph(4'h5));
            default: drive(2'b01, glyph(4'hA), 7'h7F);
        endcase
        abort_flag = 1;
        tick();
        drive(2'b11, 7'h7F, 7'h7F);
        repeat (2) tick();
        drive(2'b01, glyph(4'hA), glyph(4'hA));
        tick();
        drive(2'b11, 7'h7F, 7'h7F);
        repeat (2) tick();
        check("seg_err_count", 32'(err_obs), 32'(err_exp));
    endtask

    logic [7:0] pool [4] = '{8'hA5, 8'h3C, 8'h10, 8'hEF};

    initial begin
        logic [7:0] o, u;
        repeat (2) @(posedge clk);
        #1;
        check("rst_otp_byte", 32'(otp_byte), 32'h0);
        check("rst_user_byte", 32'(user_byte), 32'h0);
        check("rst_byte_valid", 32'(byte_valid), 32'h0);
        check("rst_match", 32'(match), 32'h0);
        check("rst_seg_err", 32'(seg_err), 32'h0);
        reset_n    = 1'b1;
        rdy_mode   = 1;
        byte_ready = 1'b1;
        tick();

        // Matching pair, then repeats that must not republish
        repeat (6) scan(8'hA5, 8'hA5, 2, 1, 2, 1);
        // Mismatching user high digit
        repeat (4) scan(8'hA5, 8'h35, 1, 0, 1, 1);
        // Bad pattern in the second scan restarts the run
        scan(8'h11, 8'h11, 1, 1, 1, 1);
        bad_scan(0);
        repeat (4) scan(8'h11, 8'h11, 2, 0, 1, 2);
        // Illegal anode aborts; blanks between digits are harmless
        bad_scan(1);
        repeat (4) scan(8'h22, 8'h2F, 1, 3, 1, 2);

        // Backpressure: A5 held while 10 becomes stable, then released
        rdy_mode   = 0;
        byte_ready = 1'b0;
        repeat (4) scan(8'hA5, 8'hA5, 1, 1, 1, 1);
        repeat (5) scan(8'h10, 8'h10, 1, 1, 1, 1);
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        scan(8'h10, 8'h10, 1, 1, 1, 2);
        rdy_mode   = 1;
        byte_ready = 1'b1;
        repeat (2) tick();

        // Reset mid-scan
        repeat (2) scan(8'h3C, 8'h3C, 1, 1, 1, 1);
        drive(2'b10, glyph(4'hC), glyph(4'hC));
        tick();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_otp_byte", 32'(otp_byte), 32'h0);
        check("mid_rst_user_byte", 32'(user_byte), 32'h0);
        check("mid_rst_byte_valid", 32'(byte_valid), 32'h0);
        check("mid_rst_match", 32'(match), 32'h0);
        check("mid_rst_seg_err", 32'(seg_err), 32'h0);
        drive(2'b11, 7'h7F, 7'h7F);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) scan(8'hA5, 8'hA5, 1, 1, 1, 1);

        // Randomized runs of repeated pairs with occasional corrupt scans
        rdy_mode = 2;
        for (int i = 0; i < 120; i++) begin
            o = pool[$urandom_range(0, 3)];
            u = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : o;
            for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
                if ($urandom_range(0, 11) == 0) bad_scan(int'($urandom_range(0, 2)));
                else scan(o, u, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                          int'($urandom_range(1, 3)), int'($urandom_range(1, 2)));
            end
        end
        rdy_mode   = 1;
        byte_ready = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/otp_seg_capture.md
# otp_seg_capture

Display-side reader for the OTP authenticator. It samples the multiplexed two-digit seven-segment bus driven by the authenticator (`lfsr_out`, `user_out`, `an`) and decodes each segment pattern back to a hex nibble. It reassembles the 8-bit OTP value and the 8-bit user-entry value, and accepts a pair only after it has been identical for a set number of complete scans. Accepted pairs go to a downstream consumer over a valid/ready handshake.

## Interface
Parameters:
- `STABLE_SCANS`, default 4: number of consecutive identical complete scans required before a pair is accepted. Range 1..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `lfsr_out`  in  7  OTP segment pattern, {g,f,e,d,c,b,a}, active-low.
- `user_out`  in  7  user-entry segment pattern, same encoding.
- `an`  in  2  anode select, active-low.
- `otp_byte`  out  8  accepted OTP value, {hi,lo}.
- `user_byte`  out  8  accepted user value, {hi,lo}.
- `byte_valid`  out  1  accepted pair available; held until taken.
- `byte_ready`  in  1  consumer accepts the pair while `byte_valid` is high.
- `match`  out  1  `otp_byte == user_byte`; see Configuration.
- `seg_err`  out  1  one-cycle pulse on an illegal anode code or an undecodable pattern.

## Operation
- **Anode decode:** 2'b10 selects digit 0 (low nibble); 2'b01 selects digit 1 (high nibble); 2'b11 is blank and is ignored; 2'b00 is illegal, pulses `seg_err` and aborts the scan.
- **Pattern decode:** the decoder recognises the 16 standard hex glyphs, e.g. 0=7'h40, 1=7'h79, 3=7'h30, 5=7'h12, A=7'h08. Any other pattern on either bus during a selected digit pulses `seg_err` and aborts the scan.
- **FSM states:** WAIT_LO, WAIT_HI, EVAL.
  - WAIT_LO: on `an`=2'b10, register both low nibbles and go to WAIT_HI.
  - WAIT_HI: on `an`=2'b10, re-register the low nibbles and stay. On `an`=2'b01, register both high nibbles and go to EVAL.
  - EVAL: lasts one cycle, then returns to WAIT_LO. In EVAL:
    - If the new candidate {otp_hi,otp_lo,user_hi,user_lo} equals the previous candidate, increment `stable_cnt`, saturating at `STABLE_SCANS`. Otherwise set `stable_cnt` to 1 and store the candidate.
    - Publish when all three hold: `stable_cnt` reaches `STABLE_SCANS` this cycle, the candidate differs from the last published pair (or nothing has been published since reset), and `byte_valid` is low.
- **Publish:** load `otp_byte`, `user_byte` and `match`, and set `byte_valid`.
- **Abort:** go to WAIT_LO, clear `stable_cnt` to 0 and invalidate the stored candidate.
- **Handshake:** a transfer occurs when `byte_valid` and `byte_ready` are both high on a rising edge; `byte_valid` clears on that edge. While `byte_valid` is high, the data outputs do not change.
- **Backpressure:** a stable pair seen while `byte_valid` is high is not dropped permanently. Because `stable_cnt` stays saturated, the pair publishes at the first EVAL after the handshake, if it still differs from the last published pair.

## Timing
- **Reset values:** all outputs are 0, the FSM is in WAIT_LO, `stable_cnt` is 0 and the "published" flag is clear.
- **Reset mid-scan:** the block returns immediately to reset state.
- **Capture:** a digit is captured on the first rising edge at which its `an` code is sampled. An anode code therefore needs to be held for at least 1 cycle.
- **Latency:** `byte_valid` rises 2 edges after the edge that samples the high digit (sample edge → EVAL → publish edge).
- **`seg_err`:** high for exactly 1 cycle, starting the edge after the offending sample.
- **Simultaneous publish and handshake:** impossible by construction, since publish requires `byte_valid` to be low.

## Configuration
- `OTP_SEG_MATCH_EN` defined: the comparator is compiled in, and `match` is registered together with the published data.
- `OTP_SEG_MATCH_EN` undefined: there is no comparator and `match` is tied to 0.

## Test plan
- **Reset:** assert `reset_n`=0 mid-scan → all outputs 0; the next publish needs `STABLE_SCANS` fresh scans.
- **Matching pair:** drive lo=5 (7'h12) and hi=A (7'h08) on both buses for 4 scans → `otp_byte`=8'hA5, `user_byte`=8'hA5, `match`=1 (with the macro), `byte_valid` 2 edges after the 4th high-digit sample.
- **Mismatch:** `user_out` hi=3 (7'h30), OTP 8'hA5, 4 scans → `user_byte`=8'h35, `match`=0.
- **Bad pattern:** 7'h7F on `lfsr_out` during digit 0 in scan 2 → one `seg_err` pulse; no publish until 4 further clean scans.
- **Backpressure:** hold `byte_ready`=0 with 8'hA5 published, then present stable 8'h10 → outputs hold A5. Raise `byte_ready` for 1 cycle → 8'h10 publishes at the next EVAL.
- **Anode codes:** an=2'b00 pulses `seg_err` and aborts; an=2'b11 between digits has no effect on capture.
